// File: rtl/serial_code_pkg.sv
// Shared definitions for the serial code link: state encoding, widths and frame length.
// Reused by the transmitter, the receive-side FSM and the benches.
package serial_code_pkg;

  localparam int CODE_W = 3;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = 2;

  // Start bit + three data bits + stop bit; parity adds one more.
  localparam int FRAME_BITS_BASE = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic int frame_cycles(input int clks_per_bit, input int parity_en);
    return (FRAME_BITS_BASE + parity_en) * clks_per_bit;
  endfunction

endpackage

// File: rtl/serial_code_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and strobes bit_tick on the
// last cycle of each bit period. Held at zero while disabled so every frame starts aligned.
module serial_code_baud
  import serial_code_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is always written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_tick = en && (cnt == LAST);

endmodule

// File: rtl/serial_code_tx.sv
// Serial code transmitter: frames a 3-bit code as start(1), MSB-first data, optional even
// parity, stop(0), with a valid/ready handshake that allows gapless back-to-back frames.
module serial_code_tx
  import serial_code_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  state_t            state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [CODE_W-1:0] shreg, shreg_d;
  logic              par, par_d;
  logic              sout_d;
  logic              out_en;
  logic              bit_tick;
  logic              stop_last;
  logic              transfer;

  serial_code_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .en       (busy),
    .bit_tick (bit_tick)
  );

  assign busy      = (state != ST_IDLE);
  assign stop_last = (state == ST_STOP) && bit_tick;
  assign done      = stop_last;
  // out_en keeps ready low during reset and for the cycle the reset edge lands in.
  assign ready     = out_en && ((state == ST_IDLE) || stop_last);
  assign transfer  = valid && ready;

  // NOTE: every variable assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    shreg_d = shreg;
    par_d   = par;
    if (transfer) begin
      state_d = ST_START;
      shreg_d = data;
      par_d   = ^data;
      idx_d   = '0;
    end else begin
      case (state)
        ST_START:  if (bit_tick) state_d = ST_DATA;
        ST_DATA: begin
          if (bit_tick) begin
            shreg_d = {shreg[CODE_W-2:0], 1'b0};
            if (idx == IDX_W'(CODE_W - 1)) begin
              idx_d   = '0;
              state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              idx_d = idx + IDX_W'(1);
            end
          end
        end
        ST_PARITY: if (bit_tick) state_d = ST_STOP;
        ST_STOP:   if (bit_tick) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end

    // sout is registered: derive the line level from the state being entered.
    case (state_d)
      ST_START:  sout_d = 1'b1;
      ST_DATA:   sout_d = shreg_d[CODE_W-1];
      ST_PARITY: sout_d = par_d;
      default:   sout_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      sout   <= 1'b0;
      out_en <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      shreg  <= shreg_d;
      par    <= par_d;
      sout   <= sout_d;
      out_en <= 1'b1;
    end
  end

endmodule
